// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit display path: digit select codes,
// the blank code the decoder renders as dark, and BCD digit limits.
package seg7_pkg;

  localparam logic [1:0] CH_RIGHT      = 2'b01;
  localparam logic [1:0] CH_LEFT       = 2'b10;
  localparam logic [3:0] BCD_BLANK     = 4'hF;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic {
    PH_RIGHT = 1'b0,
    PH_LEFT  = 1'b1
  } scan_phase_t;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the up/down counter; flags its terminal value so the
// next digit up can chain on it.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       step,
  input  logic       up_down,
  output logic [3:0] digit,
  output logic       carry_out,
  output logic       borrow_out
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clear) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_val;
    end else if (step) begin
      if (up_down) begin
        digit <= (digit == BCD_MAX_DIGIT) ? 4'd0 : digit + 4'd1;
      end else begin
        digit <= (digit == 4'd0) ? BCD_MAX_DIGIT : digit - 4'd1;
      end
    end
  end

  assign carry_out  = up_down & (digit == BCD_MAX_DIGIT);
  assign borrow_out = ~up_down & (digit == 4'd0);

endmodule

// File: rtl/bcd_counter_0_99_scan.sv
// Two-digit BCD up/down counter on a prescaled tick, with a time-multiplexed
// ones/tens output feeding the 7-segment decoder.
module bcd_counter_0_99_scan
  import seg7_pkg::*;
#(
  parameter int CLK_DIV_COUNT = 50_000_000,
  parameter int SCAN_DIV      = 50_000,
  parameter int LEADING_BLANK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up_down,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       wrap,
  output logic [3:0] bcd,
  output logic [1:0] disp_channel
);

  localparam int PW = (CLK_DIV_COUNT > 1) ? $clog2(CLK_DIV_COUNT) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV_COUNT - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [PW-1:0] pre;
  logic [SW-1:0] scan_cnt;
  scan_phase_t   phase;
  logic          tick;
  logic          load_ok;
  logic          ones_step;
  logic          tens_step;
  logic          ones_carry, ones_borrow;
  logic          tens_carry, tens_borrow;

  assign tick    = en & (pre == PRE_LAST);
  assign load_ok = load & is_bcd(load_tens) & is_bcd(load_ones);
  // Any load, even a rejected one, swallows a coincident tick.
  assign ones_step = tick & ~load & ~clear;
  assign tens_step = ones_step & (ones_carry | ones_borrow);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (clear || load) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
    end
  end

  bcd_digit u_ones (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .load       (load_ok),
    .load_val   (load_ones),
    .step       (ones_step),
    .up_down    (up_down),
    .digit      (ones),
    .carry_out  (ones_carry),
    .borrow_out (ones_borrow)
  );

  bcd_digit u_tens (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .load       (load_ok),
    .load_val   (load_tens),
    .step       (tens_step),
    .up_down    (up_down),
    .digit      (tens),
    .carry_out  (tens_carry),
    .borrow_out (tens_borrow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else if (clear) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tens_step & (tens_carry | tens_borrow);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      phase    <= PH_RIGHT;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      phase    <= (phase == PH_RIGHT) ? PH_LEFT : PH_RIGHT;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Select and digit are registered together so they can never skew.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd          <= 4'h0;
      disp_channel <= CH_RIGHT;
    end else if (phase == PH_RIGHT) begin
      bcd          <= ones;
      disp_channel <= CH_RIGHT;
    end else begin
      bcd          <= (LEADING_BLANK != 0 && tens == 4'd0) ? BCD_BLANK : tens;
      disp_channel <= CH_LEFT;
    end
  end

endmodule

// File: tb/tb_bcd_counter_0_99_scan.sv
// Bench for bcd_counter_0_99_scan: directed scenarios then random traffic,
// every cycle compared against an integer-arithmetic model of the count.
module tb_bcd_counter_0_99_scan;

  localparam int DIV  = 4;
  localparam int SDIV = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up_down = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;
  logic [3:0] tens, ones, bcd;
  logic       wrap;
  logic [1:0] disp_channel;

  int total = 0;
  int bad = 0;

  // reference model state
  int         m_count = 0;
  int         m_pre = 0;
  int         m_scan = 0;
  logic       m_wrap = 1'b0;
  logic [3:0] m_bcd = 4'h0;
  logic [1:0] m_disp = 2'b01;

  // clock / reset block
  always #5 clk = ~clk;

  bcd_counter_0_99_scan #(
    .CLK_DIV_COUNT (DIV),
    .SCAN_DIV      (SDIV),
    .LEADING_BLANK (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .up_down      (up_down),
    .clear        (clear),
    .load         (load),
    .load_tens    (load_tens),
    .load_ones    (load_ones),
    .tens         (tens),
    .ones         (ones),
    .wrap         (wrap),
    .bcd          (bcd),
    .disp_channel (disp_channel)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_edge();
    int  t, o, ph;
    logic tick;
    if (!rst_n) begin
      m_count = 0; m_pre = 0; m_scan = 0; m_wrap = 1'b0;
      m_bcd = 4'h0; m_disp = 2'b01;
      return;
    end
    t = m_count / 10;
    o = m_count % 10;
    ph = (m_scan / SDIV) % 2;
    if (ph == 0) begin
      m_bcd = 4'(o); m_disp = 2'b01;
    end else begin
      m_bcd = (t == 0) ? 4'hF : 4'(t); m_disp = 2'b10;
    end
    m_scan++;
    tick = en && (m_pre == DIV - 1);
    m_wrap = 1'b0;
    if (clear) begin
      m_count = 0; m_pre = 0;
    end else if (load) begin
      m_pre = 0;
      if (load_tens <= 4'd9 && load_ones <= 4'd9)
        m_count = int'(load_tens) * 10 + int'(load_ones);
    end else if (tick) begin
      m_pre = 0;
      if (up_down) begin
        m_wrap = (m_count == 99);
        m_count = (m_count + 1) % 100;
      end else begin
        m_wrap = (m_count == 0);
        m_count = (m_count + 99) % 100;
      end
    end else if (en) begin
      m_pre++;
    end
  endtask

  // driver: apply inputs, take one edge, compare all outputs
  task automatic cyc(input logic r, input logic e, input logic ud, input logic c,
                     input logic l, input logic [3:0] lt, input logic [3:0] lo);
    rst_n = r; en = e; up_down = ud; clear = c; load = l;
    load_tens = lt; load_ones = lo;
    @(posedge clk);
    #1;
    model_edge();
    check("tens", {4'h0, tens}, 8'(m_count / 10));
    check("ones", {4'h0, ones}, 8'(m_count % 10));
    check("wrap", {7'h0, wrap}, {7'h0, m_wrap});
    check("bcd", {4'h0, bcd}, {4'h0, m_bcd});
    check("disp_channel", {6'h0, disp_channel}, {6'h0, m_disp});
  endtask

  task automatic run(input int n, input logic e, input logic ud);
    for (int i = 0; i < n; i++) cyc(1'b1, e, ud, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic do_load(input logic [3:0] lt, input logic [3:0] lo, input logic ud);
    cyc(1'b1, 1'b1, ud, 1'b0, 1'b1, lt, lo);
  endtask

  initial begin
    // reset and first counts
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    check("reset_disp", {6'h0, disp_channel}, 8'h01);
    run(8, 1'b1, 1'b1);
    check("ones_after_8", {4'h0, ones}, 8'h02);
    // wrap up and down, down-borrow without wrap
    do_load(4'd9, 4'd9, 1'b1);
    run(5, 1'b1, 1'b1);
    do_load(4'd0, 4'd0, 1'b0);
    run(5, 1'b1, 1'b0);
    do_load(4'd1, 4'd0, 1'b0);
    run(5, 1'b1, 1'b0);
    // rejected load then valid load
    do_load(4'd5, 4'd7, 1'b1);
    run(2, 1'b1, 1'b1);
    do_load(4'hA, 4'd3, 1'b1);
    run(2, 1'b1, 1'b1);
    do_load(4'd4, 4'd2, 1'b1);
    // clear beats load and a tick at 99
    do_load(4'd9, 4'd9, 1'b1);
    run(3, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3);
    run(2, 1'b1, 1'b1);
    // scan patterns with leading blank
    do_load(4'd0, 4'd7, 1'b1);
    run(8, 1'b0, 1'b1);
    do_load(4'd4, 4'd7, 1'b1);
    run(8, 1'b0, 1'b1);
    // en dropped mid-prescale
    run(2, 1'b1, 1'b1);
    run(10, 1'b0, 1'b1);
    run(6, 1'b1, 1'b1);
    // reset in the left slot
    while (dut.disp_channel != 2'b10) run(1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    check("rst_mid_scan", {2'h0, bcd, disp_channel}, 8'h01);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, e, c, l;
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 29) == 0);
      cyc(r, e, 1'($urandom_range(0, 1)), c, l,
          4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter_0_99_scan.md
Name: bcd_counter_0_99_scan

Overview:
Upstream feeder for the 7-segment decoder on the two-digit display. Holds a two-digit BCD count 00..99 that steps up or down on a prescaled tick. Time-multiplexes the ones and tens digits onto a single bcd bus with a matching one-hot disp_channel select (01 = right/ones, 10 = left/tens). Its bcd and disp_channel outputs connect directly to the decoder's bcd and disp_channel inputs.

Parameters:
CLK_DIV_COUNT, 50_000_000, clocks per count step (>=1; a value of 1 means a step every enabled clock).
SCAN_DIV, 50_000, clocks per digit scan slot (>=1).
LEADING_BLANK, 1, if 1 the left digit shows blank (bcd=4'hF) while tens==0.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
en  in  1  count enable; gates the prescaler only.
up_down  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
clear  in  1  synchronous clear of count and prescaler.
load  in  1  synchronous load of load_tens/load_ones.
load_tens  in  4  BCD tens value for load.
load_ones  in  4  BCD ones value for load.
tens  out  4  current tens digit (registered).
ones  out  4  current ones digit (registered).
wrap  out  1  one-clock pulse on 99->00 (up) or 00->99 (down).
bcd  out  4  muxed digit to decoder (registered).
disp_channel  out  2  one-hot digit select to decoder (registered).

Behaviour:
- One clock domain (clk). Reset is synchronous, active-low, on rst_n.
- Reset values: tens=0, ones=0, wrap=0, bcd=4'h0, disp_channel=2'b01. The prescaler, scan counter and scan phase all clear to 0.
- Priority each edge: rst_n low > clear > load > tick step.
- Prescaler: counts 0..CLK_DIV_COUNT-1 only while en=1 and holds while en=0.
  - tick is asserted in the cycle the prescaler equals CLK_DIV_COUNT-1 with en=1. The prescaler then returns to 0.
  - clear or load also returns the prescaler to 0.
- Step on tick, up (up_down=1):
  - ones+1.
  - If ones==9: ones=0 and tens+1.
  - If count is 99: count becomes 00 and wrap=1 for that one clock.
- Step on tick, down (up_down=0):
  - ones-1.
  - If ones==0: ones=9 and tens-1.
  - If count is 00: count becomes 99 and wrap=1.
- Count latency: tens/ones change on the edge that samples tick. wrap rises on that same edge.
- clear: tens=ones=0, wrap=0. This overrides a coincident load or tick, and no wrap is produced.
- load:
  - If both load digits are <=9, tens/ones take the load values and wrap=0.
  - If either load digit is >9, the load is ignored entirely: count is held, no step is taken that cycle, and the prescaler still resets.
  - A coincident tick is discarded.
- Scan:
  - The scan counter runs 0..SCAN_DIV-1 on every clock, independent of en, clear and load.
  - At the terminal count the scan phase toggles.
  - phase 0 (right slot): disp_channel=01, bcd=ones.
  - phase 1 (left slot): disp_channel=10, bcd=tens, or 4'hF when LEADING_BLANK=1 and tens==0.
- bcd and disp_channel are registered from the current phase and digits each clock. Both outputs update on the same edge, one clock after a digit or phase change. They are never skewed from each other.
- disp_channel is never 00 or 11 out of reset.
- Digits are always in 0..9; the count never holds a non-BCD value.

Decomposition:
- Shared package seg7_pkg holds:
  - CH_RIGHT=2'b01 and CH_LEFT=2'b10.
  - BCD_BLANK=4'hF.
  - BCD_MAX_DIGIT=4'd9.
- Sub-module bcd_digit, instantiated twice (ones, tens):
  - Inputs: clk, rst_n, clear, load, load_val, step, up_down.
  - Outputs: digit, carry_out (up at 9) and borrow_out (down at 0).
  - The tens instance steps on step & (carry_out|borrow_out) of the ones instance.
  - wrap = tens terminal AND ones terminal on a step.

Test Plan:
- Reset with CLK_DIV_COUNT=4, SCAN_DIV=2, en=1, up -> tens/ones=0/0, disp_channel=01, bcd=0. ones=1 after 4 clocks and 2 after 8.
- Up from load 9/9 -> next tick gives 0/0 with a single-clock wrap=1. Down from 0/0 -> next tick gives 9/9 with wrap=1. Down from 1/0 -> 0/9 with no wrap.
- Load 4'hA/4'h3 while at 5/7 -> count stays 5/7 and the prescaler restarts. Load 4/2 -> 4/2 on the next edge.
- Assert clear together with load 3/3 and a tick at count 99 -> 0/0, wrap stays 0.
- Scan at count 0/7, LEADING_BLANK=1, SCAN_DIV=2:
  - bcd/disp_channel alternate 7/01 and F/10, each held 2 clocks.
  - At 4/7: alternate 7/01 and 4/10.
- Drop en for 10 clocks mid-prescale -> count and prescaler hold, scan keeps alternating.
- Drop rst_n mid-scan at phase 1 -> outputs return to reset values on the next edge.
